// File: rtl/vs_tdm_demux.sv
// Time-division demultiplexer: gathers CHANNELS consecutive words following a
// start-of-frame marker into slot registers and offers the frame as one parallel bus.
module vs_tdm_demux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sof,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      sync_err
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic              wr_en;
    logic [CW-1:0]     wr_idx;
    logic              err_nxt;
    logic              accept;
    logic [WIDTH-1:0]  slot [CHANNELS];

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= HUNT;
            cnt      <= '0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sync_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_en     = 1'b0;
        wr_idx    = '0;
        err_nxt   = 1'b0;
        case (state)
            HUNT: begin
                if (accept && in_sof) begin
                    wr_en     = 1'b1;
                    cnt_nxt   = ONE;
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (in_sof) begin
                        // Early marker: restart the frame from this word and flag it.
                        cnt_nxt = ONE;
                        err_nxt = 1'b1;
                    end else begin
                        wr_idx = cnt;
                        if (cnt == LAST) begin
                            cnt_nxt   = '0;
                            state_nxt = HOLD;
                        end else begin
                            cnt_nxt = cnt + ONE;
                        end
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    // Handoff edge may also open the next frame so frames run back-to-back.
                    if (accept && in_sof) begin
                        wr_en     = 1'b1;
                        cnt_nxt   = ONE;
                        state_nxt = COLLECT;
                    end else begin
                        state_nxt = HUNT;
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        out_valid = (state == HOLD);
        in_ready  = (state == HOLD) ? out_ready : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                slot[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (wr_idx == CW'(k)) begin
                    slot[k] <= in_data;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            out_data[k*WIDTH +: WIDTH] = slot[k];
        end
    end

endmodule
